// File: rtl/fetch_unit_pkg.sv
// Shared fetch definitions: datapath width, default boot address and the fetch FSM states.
package FetchPackage;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: issues one imem read at a time, presents the returned word with its PC,
// holds it under stall, and redirects on branch, dropping any read that was in flight.
module fetch_unit
    import FetchPackage::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            shouldUseNewPC,
    input  logic [XLEN-1:0] branchTo,
    input  logic            stall,
    output logic            imemRequest,
    output logic [XLEN-1:0] imemAddress,
    input  logic            imemReady,
    input  logic [XLEN-1:0] imemData,
    output logic [XLEN-1:0] instruction,
    output logic            instructionValid,
    output logic [XLEN-1:0] pcAddress
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic            w_capture;
    logic [XLEN-1:0] w_redirect_pc;
    logic [XLEN-1:0] w_fetch_pc_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_imem_request;
    logic [XLEN-1:0] r_imem_address;
    logic [XLEN-1:0] r_instruction;
    logic [XLEN-1:0] r_pc_address;
    logic            r_instruction_valid;

    assign w_redirect_pc = branchTo & ~XLEN'(3);

    // Next state; a redirect overrides ready and stall. With a read still in flight the
    // redirect parks in DISCARD until that stale response has been swallowed.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        if (shouldUseNewPC) begin
            case (r_state)
                REQ:     w_state_next = DISCARD;
                WAIT:    w_state_next = imemReady ? REQ : DISCARD;
                DISCARD: w_state_next = imemReady ? REQ : DISCARD;
                default: w_state_next = REQ;
            endcase
        end else begin
            case (r_state)
                REQ: w_state_next = WAIT;
                WAIT: begin
                    if (imemReady) begin
                        w_capture    = 1'b1;
                        w_state_next = stall ? HOLD : REQ;
                    end
                end
                HOLD: begin
                    if (!stall) w_state_next = REQ;
                end
                default: begin
                    if (imemReady) w_state_next = REQ;
                end
            endcase
        end
    end

    always_comb begin
        w_fetch_pc_next = r_fetch_pc;
        if (shouldUseNewPC)  w_fetch_pc_next = w_redirect_pc;
        else if (w_capture)  w_fetch_pc_next = r_fetch_pc + XLEN'(4);
    end

    // FSM state; the request strobe is registered alongside it so it tracks REQ exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= REQ;
            r_imem_request <= 1'b1;
        end else begin
            r_state        <= w_state_next;
            r_imem_request <= (w_state_next == REQ);
        end
    end

    // PC register; the bus address is loaded only on entry to REQ and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc     <= RESET_PC;
            r_imem_address <= RESET_PC;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            if (w_state_next == REQ) r_imem_address <= w_fetch_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instruction       <= '0;
            r_pc_address        <= '0;
            r_instruction_valid <= 1'b0;
        end else if (shouldUseNewPC) begin
            r_instruction_valid <= 1'b0;
        end else if (w_capture) begin
            r_instruction       <= imemData;
            r_pc_address        <= r_fetch_pc;
            r_instruction_valid <= 1'b1;
        end else if (r_instruction_valid && !stall) begin
            r_instruction_valid <= 1'b0;
        end
    end

    assign imemRequest      = r_imem_request;
    assign imemAddress      = r_imem_address;
    assign instruction      = r_instruction;
    assign pcAddress        = r_pc_address;
    assign instructionValid = r_instruction_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a transaction-level
// model (read in flight / stale / presented word) driven by a variable-latency memory responder.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        shouldUseNewPC;
    logic [31:0] branchTo;
    logic        stall;
    logic        imemRequest;
    logic [31:0] imemAddress;
    logic        imemReady;
    logic [31:0] imemData;
    logic [31:0] instruction;
    logic        instructionValid;
    logic [31:0] pcAddress;

    logic        w2_imemRequest;
    logic [31:0] w2_imemAddress;
    logic [31:0] w2_instruction;
    logic        w2_instructionValid;
    logic [31:0] w2_pcAddress;

    fetch_unit u_dut (
        .clk              (clk),
        .rst              (rst),
        .shouldUseNewPC   (shouldUseNewPC),
        .branchTo         (branchTo),
        .stall            (stall),
        .imemRequest      (imemRequest),
        .imemAddress      (imemAddress),
        .imemReady        (imemReady),
        .imemData         (imemData),
        .instruction      (instruction),
        .instructionValid (instructionValid),
        .pcAddress        (pcAddress)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk              (clk),
        .rst              (rst),
        .shouldUseNewPC   (shouldUseNewPC),
        .branchTo         (branchTo),
        .stall            (stall),
        .imemRequest      (w2_imemRequest),
        .imemAddress      (w2_imemAddress),
        .imemReady        (imemReady),
        .imemData         (imemData),
        .instruction      (w2_instruction),
        .instructionValid (w2_instructionValid),
        .pcAddress        (w2_pcAddress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // memory responder
    int          rsp_cnt     = 0;
    int          rsp_delay   = 1;
    logic [31:0] rsp_addr    = '0;
    bit          spurious_en = 1'b0;

    // reference model
    logic        m_issue, m_out, m_drop, m_valid;
    logic [31:0] m_pc, m_addr, m_instr, m_pcaddr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_issue = 1'b1; m_out = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
            m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_pcaddr = 32'h0;
        end else begin
            if (shouldUseNewPC) begin
                m_pc    = branchTo & 32'hFFFF_FFFC;
                m_valid = 1'b0;
                if (m_issue) begin
                    m_issue = 1'b0; m_out = 1'b1; m_drop = 1'b1;
                end else if (m_out && !imemReady) begin
                    m_drop = 1'b1;
                end else begin
                    m_out = 1'b0; m_issue = 1'b1;
                end
            end else if (m_issue) begin
                m_issue = 1'b0; m_out = 1'b1; m_drop = 1'b0;
                if (m_valid && !stall) m_valid = 1'b0;
            end else if (m_out) begin
                if (imemReady && !m_drop) begin
                    m_out = 1'b0; m_instr = imemData; m_pcaddr = m_pc; m_valid = 1'b1;
                    m_pc = m_pc + 32'd4; m_issue = !stall;
                end else begin
                    if (imemReady) begin m_out = 1'b0; m_issue = 1'b1; end
                    if (m_valid && !stall) m_valid = 1'b0;
                end
            end else if (!stall) begin
                m_valid = 1'b0; m_issue = 1'b1;
            end
            if (m_issue) m_addr = m_pc;
        end
    endtask

    // Drive one cycle of inputs (called at a negedge), advance the model, wait for next negedge.
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        stall = s; shouldUseNewPC = r; branchTo = t;
        imemReady = 1'b0; imemData = $urandom;
        if (rst) begin
            rsp_cnt = 0;
        end else begin
            if (rsp_cnt > 0) begin
                rsp_cnt = rsp_cnt - 1;
                if (rsp_cnt == 0) begin imemReady = 1'b1; imemData = mem_word(rsp_addr); end
            end else if (spurious_en && $urandom_range(9) == 0) begin
                imemReady = 1'b1;
            end
            if (imemRequest === 1'b1) begin
                rsp_cnt  = (rsp_delay == 0) ? int'($urandom_range(3, 1)) : rsp_delay;
                rsp_addr = imemAddress;
            end
        end
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        n_run++;
        if (imemRequest !== 1'b1 || imemAddress !== 32'h0 || instructionValid !== 1'b0 ||
            instruction !== 32'h0 || pcAddress !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got req=%b addr=%h v=%b ins=%h pc=%h want 1/0/0/0/0",
                     imemRequest, imemAddress, instructionValid, instruction, pcAddress);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        rsp_delay = 1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            n_run++;
            if (imemRequest !== 1'b1 || imemAddress !== 32'(4 * k)) begin
                n_fail++;
                $display("FAIL seq_req%0d: got req=%b addr=%h want 1 %h", k, imemRequest, imemAddress, 32'(4 * k));
            end
            step(1'b0, 1'b0, 32'h0);
            n_run++;
            if (imemRequest !== 1'b0 || instructionValid !== 1'b0) begin
                n_fail++;
                $display("FAIL seq_wait%0d: got req=%b v=%b want 0 0", k, imemRequest, instructionValid);
            end
            step(1'b0, 1'b0, 32'h0);
            n_run++;
            if (instructionValid !== 1'b1 || pcAddress !== 32'(4 * k) || instruction !== mem_word(32'(4 * k))) begin
                n_fail++;
                $display("FAIL seq_valid%0d: got v=%b pc=%h ins=%h want 1 %h %h", k, instructionValid,
                         pcAddress, instruction, 32'(4 * k), mem_word(32'(4 * k)));
            end
        end
    endtask

    task automatic test_stall();
        rsp_delay = 1;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if (instructionValid !== 1'b1 || pcAddress !== 32'h4 || instruction !== mem_word(32'h4) ||
                imemRequest !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h ins=%h req=%b want 1 00000004 %h 0",
                         i, instructionValid, pcAddress, instruction, imemRequest, mem_word(32'h4));
            end
            if (i < 4) step(1'b1, 1'b0, 32'h0);
        end
        step(1'b0, 1'b0, 32'h0);
        n_run++;
        if (imemRequest !== 1'b1 || imemAddress !== 32'h8 || instructionValid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got req=%b addr=%h v=%b want 1 00000008 0",
                     imemRequest, imemAddress, instructionValid);
        end
    endtask

    task automatic test_redirect_wait();
        int waited;
        rsp_delay = 4;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hAABC_CCDC);
        waited = 0;
        while (imemRequest !== 1'b1 && waited < 10) begin
            n_run++;
            if (instructionValid !== 1'b0) begin
                n_fail++;
                $display("FAIL redir_wait_valid: got v=%b want 0", instructionValid);
            end
            step(1'b0, 1'b0, 32'h0);
            waited++;
        end
        n_run++;
        if (imemRequest !== 1'b1 || imemAddress !== 32'hAABC_CCDC || instructionValid !== 1'b0 ||
            instruction !== 32'h0 || waited != 3) begin
            n_fail++;
            $display("FAIL redir_wait_next: got req=%b addr=%h v=%b ins=%h after %0d want 1 aabcccdc 0 0 after 3",
                     imemRequest, imemAddress, instructionValid, instruction, waited);
        end
    endtask

    task automatic test_redirect_ready();
        rsp_delay = 1;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hA2AA_EF33);
        n_run++;
        if (imemRequest !== 1'b1 || imemAddress !== 32'hA2AA_EF30 || instructionValid !== 1'b0 ||
            instruction !== 32'h0) begin
            n_fail++;
            $display("FAIL redir_ready: got req=%b addr=%h v=%b ins=%h want 1 a2aaef30 0 0",
                     imemRequest, imemAddress, instructionValid, instruction);
        end
    endtask

    task automatic test_wrap();
        rsp_delay = 1;
        do_reset();
        n_run++;
        if (w2_imemRequest !== 1'b1 || w2_imemAddress !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_first: got req=%b addr=%h want 1 fffffffc", w2_imemRequest, w2_imemAddress);
        end
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        n_run++;
        if (w2_imemRequest !== 1'b1 || w2_imemAddress !== 32'h0 || w2_pcAddress !== 32'hFFFF_FFFC ||
            w2_instructionValid !== 1'b1 || w2_instruction !== mem_word(32'h0)) begin
            n_fail++;
            $display("FAIL wrap_second: got req=%b addr=%h pc=%h v=%b ins=%h want 1 00000000 fffffffc 1 %h",
                     w2_imemRequest, w2_imemAddress, w2_pcAddress, w2_instructionValid, w2_instruction,
                     mem_word(32'h0));
        end
    endtask

    task automatic test_reset_in_wait();
        rsp_delay = 2;
        do_reset();
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        n_run++;
        if (instructionValid !== 1'b1 || imemRequest !== 1'b0 || imemAddress !== 32'h4) begin
            n_fail++;
            $display("FAIL rstwait_setup: got v=%b req=%b addr=%h want 1 0 00000004",
                     instructionValid, imemRequest, imemAddress);
        end
        rst = 1'b1;
        step(1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        n_run++;
        if (imemRequest !== 1'b1 || imemAddress !== 32'h0 || instructionValid !== 1'b0 ||
            instruction !== 32'h0 || pcAddress !== 32'h0) begin
            n_fail++;
            $display("FAIL rstwait_state: got req=%b addr=%h v=%b ins=%h pc=%h want 1 0 0 0 0",
                     imemRequest, imemAddress, instructionValid, instruction, pcAddress);
        end
    endtask

    task automatic test_random();
        int bad;
        rsp_delay   = 0;
        spurious_en = 1'b1;
        do_reset();
        bad = 0;
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(199) == 0);
            step(($urandom_range(9) < 3), ($urandom_range(99) < 8), $urandom);
            n_run++;
            if (imemRequest !== m_issue || imemAddress !== m_addr || instructionValid !== m_valid ||
                instruction !== m_instr || pcAddress !== m_pcaddr) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_c%0d: got req=%b addr=%h v=%b ins=%h pc=%h want req=%b addr=%h v=%b ins=%h pc=%h",
                             c, imemRequest, imemAddress, instructionValid, instruction, pcAddress,
                             m_issue, m_addr, m_valid, m_instr, m_pcaddr);
            end
        end
        rst         = 1'b0;
        spurious_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; shouldUseNewPC = 1'b0; branchTo = '0;
        imemReady = 1'b0; imemData = '0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_ready();
        test_wrap();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
